// File: rtl/fp32_pkg.sv
// Shared binary32 types, constants and operand classification helpers
// for the fp32 arithmetic units.
package fp32_pkg;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] mant;
   } fp32_t;

   typedef enum logic [1:0] {
      SPC_NONE,
      SPC_ZERO,
      SPC_INF,
      SPC_NAN
   } special_e;

   localparam int          FP32_BIAS    = 127;
   localparam int          FP32_EXP_MAX = 255;
   localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;
   localparam logic [31:0] FP32_INF     = 32'h7F800000;

   // Subnormals are treated as zero: any operand with a zero exponent.
   function automatic logic is_zero(input fp32_t x);
      return x.exp == 8'd0;
   endfunction

   function automatic logic is_inf(input fp32_t x);
      return (x.exp == 8'(FP32_EXP_MAX)) && (x.mant == 23'd0);
   endfunction

   function automatic logic is_nan(input fp32_t x);
      return (x.exp == 8'(FP32_EXP_MAX)) && (x.mant != 23'd0);
   endfunction

   function automatic special_e classify_mul(input fp32_t a, input fp32_t b);
      if (is_nan(a) || is_nan(b) || (is_inf(a) && is_zero(b)) || (is_inf(b) && is_zero(a)))
         return SPC_NAN;
      else if (is_inf(a) || is_inf(b))
         return SPC_INF;
      else if (is_zero(a) || is_zero(b))
         return SPC_ZERO;
      else
         return SPC_NONE;
   endfunction

endpackage

// File: rtl/fp32_round.sv
// Round-to-nearest-even of a normalized 24-bit mantissa, with overflow to
// infinity and flush-to-zero on underflow. Purely combinational.
module fp32_round
   import fp32_pkg::*;
(
   input  logic              sign,
   input  logic signed [9:0] exp,
   input  logic [23:0]       mant,
   input  logic              guard,
   input  logic              round_bit,
   input  logic              sticky,
   output logic [31:0]       result
);

   logic              inc;
   logic [24:0]       sum;
   logic signed [9:0] exp_f;
   logic [22:0]       mant_f;

   always_comb begin
      inc = guard & (round_bit | sticky | mant[0]);
      sum = {1'b0, mant} + {24'd0, inc};
      // A carry out of the mantissa means 1.111..1 rounded up to 10.000..0.
      if (sum[24]) begin
         exp_f  = exp + 10'sd1;
         mant_f = sum[23:1];
      end else begin
         exp_f  = exp;
         mant_f = sum[22:0];
      end
      if (exp_f >= 10'sd255)
         result = {sign, FP32_INF[30:0]};
      else if (exp_f <= 10'sd0)
         result = {sign, 31'd0};
      else
         result = {sign, exp_f[7:0], mant_f};
   end

endmodule

// File: rtl/fp32_mul.sv
// Four-stage pipelined binary32 multiplier: unpack, multiply, normalize,
// round/select. One operand pair per cycle, no stalls.
module fp32_mul
   import fp32_pkg::*;
(
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        valid_in,
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   output logic        valid_out,
   output logic [31:0] c_out
);

   fp32_t             a;
   fp32_t             b;
   logic signed [9:0] exp_sum;
   logic [3:0]        vpipe;

   assign a       = fp32_t'(a_in);
   assign b       = fp32_t'(b_in);
   assign exp_sum = 10'({2'b00, a.exp}) + 10'({2'b00, b.exp}) - 10'(FP32_BIAS);

   // valid_in delayed by the pipeline depth; cleared by reset so in-flight
   // operations are discarded.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) vpipe <= 4'd0;
      else        vpipe <= {vpipe[2:0], valid_in};
   end
   assign valid_out = vpipe[3];

   // Stage 1: unpack
   logic              s1_sign;
   logic signed [9:0] s1_exp;
   logic [23:0]       s1_ma;
   logic [23:0]       s1_mb;
   special_e          s1_spec;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         s1_sign <= 1'b0;
         s1_exp  <= 10'sd0;
         s1_ma   <= 24'd0;
         s1_mb   <= 24'd0;
         s1_spec <= SPC_NONE;
      end else begin
         s1_sign <= a.sign ^ b.sign;
         s1_exp  <= exp_sum;
         s1_ma   <= {1'b1, a.mant};
         s1_mb   <= {1'b1, b.mant};
         s1_spec <= classify_mul(a, b);
      end
   end

   // Stage 2: multiply
   logic              s2_sign;
   logic signed [9:0] s2_exp;
   logic [47:0]       s2_prod;
   special_e          s2_spec;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         s2_sign <= 1'b0;
         s2_exp  <= 10'sd0;
         s2_prod <= 48'd0;
         s2_spec <= SPC_NONE;
      end else begin
         s2_sign <= s1_sign;
         s2_exp  <= s1_exp;
         s2_prod <= s1_ma * s1_mb;
         s2_spec <= s1_spec;
      end
   end

   // Stage 3: normalize; the product of two [1,2) mantissas lies in [1,4).
   logic signed [9:0] norm_exp;
   logic [23:0]       norm_mant;
   logic              norm_g;
   logic              norm_r;
   logic              norm_s;

   always_comb begin
      if (s2_prod[47]) begin
         norm_exp  = s2_exp + 10'sd1;
         norm_mant = s2_prod[47:24];
         norm_g    = s2_prod[23];
         norm_r    = s2_prod[22];
         norm_s    = |s2_prod[21:0];
      end else begin
         norm_exp  = s2_exp;
         norm_mant = s2_prod[46:23];
         norm_g    = s2_prod[22];
         norm_r    = s2_prod[21];
         norm_s    = |s2_prod[20:0];
      end
   end

   logic              s3_sign;
   logic signed [9:0] s3_exp;
   logic [23:0]       s3_mant;
   logic              s3_g;
   logic              s3_r;
   logic              s3_s;
   special_e          s3_spec;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         s3_sign <= 1'b0;
         s3_exp  <= 10'sd0;
         s3_mant <= 24'd0;
         s3_g    <= 1'b0;
         s3_r    <= 1'b0;
         s3_s    <= 1'b0;
         s3_spec <= SPC_NONE;
      end else begin
         s3_sign <= s2_sign;
         s3_exp  <= norm_exp;
         s3_mant <= norm_mant;
         s3_g    <= norm_g;
         s3_r    <= norm_r;
         s3_s    <= norm_s;
         s3_spec <= s2_spec;
      end
   end

   // Stage 4: round, then let special operands override the numeric result.
   logic [31:0] rounded;
   logic [31:0] c_next;

   fp32_round u_round (
      .sign      (s3_sign),
      .exp       (s3_exp),
      .mant      (s3_mant),
      .guard     (s3_g),
      .round_bit (s3_r),
      .sticky    (s3_s),
      .result    (rounded)
   );

   always_comb begin
      c_next = rounded;
      case (s3_spec)
         SPC_NAN:  c_next = FP32_QNAN;
         SPC_INF:  c_next = {s3_sign, FP32_INF[30:0]};
         SPC_ZERO: c_next = {s3_sign, 31'd0};
         default:  c_next = rounded;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) c_out <= 32'd0;
      else        c_out <= c_next;
   end

endmodule

// File: tb/tb_fp32_mul.sv
// Scoreboard bench for fp32_mul: directed vectors, reset mid-flight and
// randomized operands checked against an exact-arithmetic reference.
module tb_fp32_mul;

   logic        clk_in   = 1'b0;
   logic        rst_in   = 1'b0;
   logic        valid_in = 1'b0;
   logic [31:0] a_in     = 32'd0;
   logic [31:0] b_in     = 32'd0;
   logic        valid_out;
   logic [31:0] c_out;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [31:0] exp_q[$];
   int          exp_t[$];

   fp32_mul dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .valid_in  (valid_in),
      .a_in      (a_in),
      .b_in      (b_in),
      .valid_out (valid_out),
      .c_out     (c_out)
   );

   // clock / cycle counter
   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   // Reference: exact integer product rounded to nearest-even from the
   // full remainder, then the special-value priority rules.
   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      int ea, eb, e, sh;
      logic s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      longint unsigned ma, mb, p, q, rem, half;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      s  = a[31] ^ b[31];
      a_zero = (ea == 0);
      b_zero = (eb == 0);
      a_inf  = (ea == 255) && (a[22:0] == 23'd0);
      b_inf  = (eb == 255) && (b[22:0] == 23'd0);
      a_nan  = (ea == 255) && (a[22:0] != 23'd0);
      b_nan  = (eb == 255) && (b[22:0] != 23'd0);
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC00000;
      if (a_inf || b_inf) return {s, 8'hFF, 23'd0};
      if (a_zero || b_zero) return {s, 31'd0};
      ma = {40'd0, 1'b1, a[22:0]};
      mb = {40'd0, 1'b1, b[22:0]};
      p  = ma * mb;
      sh = (p >= (64'd1 << 47)) ? 24 : 23;
      e  = ea + eb - 127 + (sh - 23);
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q == (64'd1 << 24)) begin
         q = q >> 1;
         e = e + 1;
      end
      if (e >= 255) return {s, 8'hFF, 23'd0};
      if (e <= 0) return {s, 31'd0};
      return {s, 8'(e), q[22:0]};
   endfunction

   function automatic logic [31:0] rand_fp();
      logic [7:0] e;
      int sel;
      sel = int'($urandom_range(0, 15));
      case (sel)
         0:       e = 8'd0;
         1, 2:    e = 8'hFF;
         3:       e = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(1, 12)) : 8'($urandom_range(243, 254));
         default: e = 8'($urandom_range(64, 190));
      endcase
      if (sel == 1) return {1'($urandom_range(0, 1)), e, 23'd0};
      return {1'($urandom_range(0, 1)), e, 23'($urandom)};
   endfunction

   // driver tasks
   task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      @(negedge clk_in);
      valid_in = 1'b1;
      a_in     = a;
      b_in     = b;
      exp_q.push_back(c);
      exp_t.push_back(cyc);
   endtask

   task automatic drive_idle();
      @(negedge clk_in);
      valid_in = 1'b0;
      a_in     = $urandom;
      b_in     = $urandom;
   endtask

   // monitor / scoreboard
   initial begin
      logic        due;
      logic [31:0] e;
      int          t;
      forever begin
         @(negedge clk_in or posedge rst_in);
         if (rst_in) begin
            #1;
            checks = checks + 2;
            if (valid_out !== 1'b0) begin
               failures = failures + 1;
               $display("FAIL reset_valid: got %b want 0 (t=%0t)", valid_out, $time);
            end
            if (c_out !== 32'd0) begin
               failures = failures + 1;
               $display("FAIL reset_c_out: got %08h want 00000000 (t=%0t)", c_out, $time);
            end
         end else begin
            due = (exp_t.size() > 0) && (cyc - exp_t[0] >= 4);
            checks = checks + 1;
            if (valid_out !== due) begin
               failures = failures + 1;
               $display("FAIL valid_out: got %b want %b (cycle %0d)", valid_out, due, cyc);
            end
            if (due) begin
               e = exp_q.pop_front();
               t = exp_t.pop_front();
               if (valid_out === 1'b1) begin
                  checks = checks + 1;
                  if (c_out !== e || cyc - t != 4) begin
                     failures = failures + 1;
                     $display("FAIL product: got %08h want %08h latency got %0d want 4", c_out, e, cyc - t);
                  end
               end
            end
         end
      end
   end

   logic [31:0] dir_a [0:12] = '{32'h43970FFD, 32'h3DFFCB92, 32'hC141BE77, 32'h3DE31F8A,
                                  32'h00000000, 32'h7F800000, 32'h7F800000, 32'h7FC00001,
                                  32'h00400000, 32'h7F000000, 32'h00800000, 32'h3F800001,
                                  32'h3FFFFFFF};
   logic [31:0] dir_b [0:12] = '{32'h40C91759, 32'h3FA45D64, 32'h40E6C99B, 32'hBDD53261,
                                  32'hC0000000, 32'h3F800000, 32'h00000000, 32'h3F800000,
                                  32'h40000000, 32'h40000000, 32'h3F000000, 32'h3F800001,
                                  32'h3FFFFFFF};
   logic [31:0] dir_c [0:12] = '{32'h44ED52A9, 32'h3E243BBA, 32'hC2AEA9B3, 32'hBC3D25F0,
                                  32'h80000000, 32'h7F800000, 32'h7FC00000, 32'h7FC00000,
                                  32'h00000000, 32'h7F800000, 32'h00000000, 32'h3F800002,
                                  32'h407FFFFE};

   // main stimulus
   initial begin
      logic [31:0] ra, rb;
      #2 rst_in = 1'b1;
      repeat (3) @(negedge clk_in);
      rst_in = 1'b0;
      repeat (2) drive_idle();

      // back-to-back normals, 1/0/1/0 gating, specials, overflow, rounding
      for (int i = 0; i < 13; i++) begin
         drive_op(dir_a[i], dir_b[i], dir_c[i]);
         if (i == 4 || i == 5) drive_idle();
      end
      repeat (8) drive_idle();

      // reset with three operations in flight
      for (int i = 0; i < 3; i++) begin
         ra = rand_fp();
         rb = rand_fp();
         drive_op(ra, rb, ref_mul(ra, rb));
      end
      @(posedge clk_in);
      #3;
      rst_in   = 1'b1;
      valid_in = 1'b0;
      exp_q.delete();
      exp_t.delete();
      repeat (3) @(negedge clk_in);
      rst_in = 1'b0;
      repeat (2) drive_idle();
      drive_op(dir_a[0], dir_b[0], dir_c[0]);
      repeat (8) drive_idle();

      // randomized stream with random gaps
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) != 0) begin
            ra = rand_fp();
            rb = rand_fp();
            drive_op(ra, rb, ref_mul(ra, rb));
         end else begin
            drive_idle();
         end
      end
      repeat (10) drive_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
